// File: rtl/neuron_pkg.sv
// Shared definitions for the spiking neuron: coupling-code values, spike-word field helpers
// and signed saturation.
package neuron_pkg;

  localparam logic [1:0] Q_ZERO = 2'd0;
  localparam logic [1:0] Q_POS  = 2'd1;
  localparam logic [1:0] Q_NEG  = 2'd2;

  function automatic int spike_valid_bit(input int spike_w);
    return spike_w - 1;
  endfunction

  // Code 3 is reserved and treated like Q_ZERO.
  function automatic logic signed [1:0] q_weight(input logic [1:0] code);
    case (code)
      Q_POS:   return 2'sb01;
      Q_NEG:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

  // Clamp a wide signed sum into the range of a w-bit signed value (w <= 32).
  function automatic logic signed [31:0] sat_to(input logic signed [32:0] x, input int w);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (x > hi)      return hi[31:0];
    else if (x < lo) return lo[31:0];
    else             return x[31:0];
  endfunction

endpackage

// File: rtl/neuron_q_ram.sv
// Coupling-row storage: one write port, one registered read port; a same-address
// read and write in one cycle returns the old contents.
module neuron_q_ram #(
  parameter int AW = 10,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] ram [2**AW];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/neuron_core.sv
// Single Ising-style spiking neuron: loads its coupling row, threshold and index, integrates
// incoming spikes through a two-stage pipeline and fires its own index when Vmem reaches mu.
module neuron_core
  import neuron_pkg::*;
#(
  parameter int MU_DATA_WIDTH    = 16,
  parameter int VMEM_DATA_WIDTH  = 16,
  parameter int Q_ADDR_WIDTH     = 10,
  parameter int Q_DATA_WIDTH     = 2,
  parameter int SPIKE_DATA_WIDTH = 12,
  parameter int SPIKE_ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        reset_l,
  input  logic                        en_neuron,
  input  logic                        en_spike,
  input  logic                        wrQ,
  input  logic                        wrVmem,
  input  logic                        wrNeuronI,
  input  logic                        wrMu,
  input  logic [SPIKE_ADDR_WIDTH-1:0] neuronI_in,
  input  logic [VMEM_DATA_WIDTH-1:0]  Vmem_in,
  input  logic [Q_DATA_WIDTH-1:0]     Q_in,
  input  logic [MU_DATA_WIDTH-1:0]    mu_in,
  input  logic [SPIKE_DATA_WIDTH-1:0] spike_in,
  input  logic                        networkDone,
  output logic [MU_DATA_WIDTH-1:0]    mu_out,
  output logic [SPIKE_DATA_WIDTH-1:0] spike_out,
  output logic                        neuronWrDone
);

  localparam int VALID_BIT = spike_valid_bit(SPIKE_DATA_WIDTH);

  logic [Q_ADDR_WIDTH-1:0]            wptr;
  logic signed [VMEM_DATA_WIDTH-1:0]  vmem;
  logic signed [MU_DATA_WIDTH-1:0]    mu;
  logic [SPIKE_ADDR_WIDTH-1:0]        neuron_i;
  logic                               got_q, got_v, got_i, got_m;
  logic                               s1_valid;
  logic [Q_DATA_WIDTH-1:0]            q_rd;
  logic [SPIKE_ADDR_WIDTH-1:0]        in_idx;
  logic                               accept;
  logic signed [32:0]                 sum_ext;
  logic signed [VMEM_DATA_WIDTH-1:0]  nv;
  logic                               fire;
  logic [SPIKE_DATA_WIDTH-1:0]        fire_word;
  logic                               unused_bits;

  assign in_idx      = spike_in[SPIKE_ADDR_WIDTH-1:0];
  assign unused_bits = ^spike_in[VALID_BIT-1:SPIKE_ADDR_WIDTH];
  assign accept      = en_neuron & en_spike & ~networkDone & spike_in[VALID_BIT] & (in_idx != neuron_i);
  assign mu_out      = mu;

  neuron_q_ram #(.AW(Q_ADDR_WIDTH), .DW(Q_DATA_WIDTH)) Q_ram (
    .clk   (clk),
    .we    (en_neuron & wrQ),
    .waddr (wptr),
    .wdata (Q_in),
    .re    (accept),
    .raddr (Q_ADDR_WIDTH'(in_idx)),
    .rdata (q_rd)
  );

  assign sum_ext = 33'(vmem) + 33'(q_weight(q_rd[1:0]));
  assign nv      = VMEM_DATA_WIDTH'(sat_to(sum_ext, VMEM_DATA_WIDTH));
  assign fire    = (32'(nv) >= 32'(mu));

  always_comb begin
    fire_word = '0;
    fire_word[VALID_BIT] = 1'b1;
    fire_word[SPIKE_ADDR_WIDTH-1:0] = neuron_i;
  end

  always_ff @(posedge clk or posedge reset_l) begin
    if (reset_l) begin
      wptr         <= '0;
      vmem         <= '0;
      mu           <= '0;
      neuron_i     <= '0;
      got_q        <= 1'b0;
      got_v        <= 1'b0;
      got_i        <= 1'b0;
      got_m        <= 1'b0;
      s1_valid     <= 1'b0;
      spike_out    <= '0;
      neuronWrDone <= 1'b0;
    end else if (!en_neuron) begin
      // Stalled: pipeline and config hold, only the pulse output drops.
      spike_out <= '0;
    end else begin
      if (wrQ) begin
        wptr  <= wptr + 1'b1;
        got_q <= 1'b1;
      end
      if (wrNeuronI) begin
        neuron_i <= neuronI_in;
        got_i    <= 1'b1;
      end
      if (wrMu) begin
        mu    <= mu_in;
        got_m <= 1'b1;
      end
      if ((got_q | wrQ) & (got_v | wrVmem) & (got_i | wrNeuronI) & (got_m | wrMu))
        neuronWrDone <= 1'b1;

      spike_out <= '0;
      if (networkDone) begin
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (s1_valid && !wrVmem) begin
          if (fire) begin
            vmem      <= '0;
            spike_out <= fire_word;
          end else begin
            vmem <= nv;
          end
        end
      end

      // An explicit load overrides any integration result in the same cycle.
      if (wrVmem) begin
        vmem  <= Vmem_in;
        got_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_core.sv
// Directed and randomized checks of neuron_core against a plain-integer model of the neuron.
module tb_neuron_core;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        en_neuron, en_spike, wrQ, wrVmem, wrNeuronI, wrMu, networkDone;
  logic [9:0]  neuronI_in;
  logic [15:0] Vmem_in;
  logic [1:0]  Q_in;
  logic [15:0] mu_in;
  logic [11:0] spike_in;
  logic [15:0] mu_out;
  logic [11:0] spike_out;
  logic        neuronWrDone;

  int checks = 0;
  int errors = 0;
  int q_model [64];

  localparam int SELF = 7;
  localparam logic [11:0] FIRE_WORD = 12'h807;

  neuron_core dut (
    .clk(clk), .reset_l(reset_l), .en_neuron(en_neuron), .en_spike(en_spike),
    .wrQ(wrQ), .wrVmem(wrVmem), .wrNeuronI(wrNeuronI), .wrMu(wrMu),
    .neuronI_in(neuronI_in), .Vmem_in(Vmem_in), .Q_in(Q_in), .mu_in(mu_in),
    .spike_in(spike_in), .networkDone(networkDone), .mu_out(mu_out),
    .spike_out(spike_out), .neuronWrDone(neuronWrDone)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int weight_of(input int code);
    if (code == 1) return 1;
    if (code == 2) return -1;
    return 0;
  endfunction

  initial begin
    int mdl_v, mdl_mu, idx, e;
    bit valid;
    logic [11:0] expq [$];

    reset_l = 1'b1; en_neuron = 1'b0; en_spike = 1'b0; wrQ = 1'b0; wrVmem = 1'b0;
    wrNeuronI = 1'b0; wrMu = 1'b0; networkDone = 1'b0; neuronI_in = '0; Vmem_in = '0;
    Q_in = '0; mu_in = '0; spike_in = '0;
    tick(); tick();
    reset_l = 1'b0;
    chk("rst_spike_out", spike_out, 0);
    chk("rst_mu_out", mu_out, 0);
    chk("rst_done", neuronWrDone, 0);
    chk("rst_wptr", dut.wptr, 0);
    chk("rst_vmem", dut.vmem, 0);

    // Sequential Q load
    en_neuron = 1'b1;
    wrQ = 1'b1;
    for (int i = 0; i < 64; i++) begin
      Q_in = 2'(i % 3);
      tick();
    end
    wrQ = 1'b0;
    for (int i = 0; i < 64; i++) chk("qload_ram", dut.Q_ram.ram[i], i % 3);
    chk("qload_wptr", dut.wptr, 64);
    chk("done_q_only", neuronWrDone, 0);

    wrVmem = 1'b1; Vmem_in = 16'd5; wrNeuronI = 1'b1; neuronI_in = 10'd7; wrMu = 1'b1; mu_in = 16'd3;
    tick();
    wrVmem = 1'b0; wrNeuronI = 1'b0; wrMu = 1'b0;
    chk("done_set", neuronWrDone, 1);
    chk("mu_out_3", mu_out, 3);

    // Asynchronous reset in the middle of a Q load
    wrQ = 1'b1; Q_in = 2'd1;
    tick(); tick(); tick();
    #2 reset_l = 1'b1;
    #1;
    chk("midrst_wptr", dut.wptr, 0);
    chk("midrst_vmem", dut.vmem, 0);
    chk("midrst_mu", mu_out, 0);
    chk("midrst_done", neuronWrDone, 0);
    chk("midrst_spike", spike_out, 0);
    @(negedge clk);
    reset_l = 1'b0;

    for (int i = 0; i < 64; i++) q_model[i] = $urandom_range(0, 3);
    q_model[2] = 1; q_model[4] = 2; q_model[SELF] = 1;
    for (int i = 0; i < 64; i++) begin
      Q_in = 2'(q_model[i]);
      tick();
      if (i == 0) begin
        chk("post_rst_addr0", dut.Q_ram.ram[0], q_model[0]);
        chk("post_rst_wptr1", dut.wptr, 1);
      end
    end
    wrQ = 1'b0;
    chk("reload_wptr", dut.wptr, 64);
    chk("reload_q2", dut.Q_ram.ram[2], 1);
    chk("done_after_rst", neuronWrDone, 0);

    wrVmem = 1'b1; Vmem_in = 16'd2; wrNeuronI = 1'b1; neuronI_in = 10'(SELF); wrMu = 1'b1; mu_in = 16'd3;
    tick();
    wrVmem = 1'b0; wrNeuronI = 1'b0; wrMu = 1'b0;
    chk("done_reload", neuronWrDone, 1);

    // Fire: 2 + 1 reaches mu=3
    en_spike = 1'b1;
    spike_in = 12'h802; tick(); spike_in = '0;
    chk("fire_lat1", spike_out, 0);
    tick();
    chk("fire_word", spike_out, FIRE_WORD);
    chk("fire_vmem", dut.vmem, 0);
    tick();
    chk("fire_pulse", spike_out, 0);

    // Negative saturation
    wrVmem = 1'b1; Vmem_in = 16'h8000; tick(); wrVmem = 1'b0;
    spike_in = 12'h804; tick(); spike_in = '0; tick();
    chk("sat_vmem", dut.vmem, -32768);
    chk("sat_spike", spike_out, 0);

    // Self-index and invalid spikes are ignored
    wrVmem = 1'b1; Vmem_in = 16'd1; tick(); wrVmem = 1'b0;
    spike_in = 12'h807; tick(); spike_in = '0; tick(); tick();
    chk("self_vmem", dut.vmem, 1);
    spike_in = 12'h002; tick(); spike_in = '0; tick(); tick();
    chk("invalid_vmem", dut.vmem, 1);

    // networkDone freezes integration but allows config writes
    networkDone = 1'b1;
    spike_in = 12'h802; tick(); spike_in = '0; tick();
    chk("nd_spike", spike_out, 0);
    tick();
    chk("nd_vmem", dut.vmem, 1);
    wrMu = 1'b1; mu_in = 16'd4; tick(); wrMu = 1'b0;
    chk("nd_mu_write", mu_out, 4);
    wrMu = 1'b1; mu_in = 16'd3; networkDone = 1'b0; tick(); wrMu = 1'b0;

    // In-flight spike discarded by networkDone
    spike_in = 12'h802; tick(); spike_in = '0;
    networkDone = 1'b1; tick();
    chk("discard_spike", spike_out, 0);
    networkDone = 1'b0; tick();
    chk("discard_vmem", dut.vmem, 1);

    // wrVmem overrides a pending fire
    wrVmem = 1'b1; Vmem_in = 16'd2; tick(); wrVmem = 1'b0;
    spike_in = 12'h802; tick(); spike_in = '0;
    wrVmem = 1'b1; Vmem_in = 16'd10; tick(); wrVmem = 1'b0;
    chk("wrvmem_wins_vmem", dut.vmem, 10);
    chk("wrvmem_wins_spike", spike_out, 0);

    // Stall with en_neuron low mid-pipeline
    wrVmem = 1'b1; Vmem_in = 16'd2; tick(); wrVmem = 1'b0;
    spike_in = 12'h802; tick(); spike_in = '0;
    en_neuron = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_spike", spike_out, 0);
    end
    chk("stall_vmem", dut.vmem, 2);
    en_neuron = 1'b1; tick();
    chk("resume_spike", spike_out, FIRE_WORD);
    chk("resume_vmem", dut.vmem, 0);

    // Randomized back-to-back spikes against the integer model
    mdl_v = 0; mdl_mu = 5;
    wrVmem = 1'b1; Vmem_in = 16'd0; wrMu = 1'b1; mu_in = 16'd5; tick();
    wrVmem = 1'b0; wrMu = 1'b0;
    for (int c = 0; c <= 400; c++) begin
      e = 0;
      if (c < 400) begin
        valid = ($urandom_range(0, 7) != 0);
        idx = (($urandom_range(0, 15) == 0) ? SELF : $urandom_range(0, 63));
        spike_in = {valid, 1'b0, 10'(idx)};
        if (valid && idx != SELF) begin
          mdl_v = mdl_v + weight_of(q_model[idx]);
          if (mdl_v > 32767) mdl_v = 32767;
          if (mdl_v < -32768) mdl_v = -32768;
          if (mdl_v >= mdl_mu) begin
            mdl_v = 0;
            e = FIRE_WORD;
          end
        end
      end else begin
        spike_in = '0;
      end
      expq.push_back(12'(e));
      tick();
      if (expq.size() == 2) begin
        chk("rnd_spike_out", spike_out, expq[0]);
        expq.pop_front();
      end
    end
    chk("rnd_final_vmem", dut.vmem, mdl_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
